// File: rtl/bram_stream_bridge.sv
// Frame buffer bridge: fills one frame into a dual-port RAM from a valid/ready
// stream, then replays it in order. Define BRAM_STREAM_PINGPONG_EN for two-bank overlap.
module bram_stream_bridge #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 9,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frame_done,
    output logic [AWIDTH-1:0] addr1,
    output logic              ce1,
    output logic              we1,
    output logic [DWIDTH-1:0] d1,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    input  logic [DWIDTH-1:0] q0
);
    // One extra bit so rd_cnt can reach FRAME_LEN, which marks "all reads issued".
    localparam int            CW   = AWIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FLEN = CW'(FRAME_LEN);

    logic              fill_active, drain_active;
    logic              wr_fire, last_beat, pop, last_pop, issue;
    logic [CW-1:0]     wr_cnt, rd_cnt, rd_idx_q;
    logic              rd_pend;
    logic [DWIDTH-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic              buf_rd, buf_wr;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ_next;

    assign s_ready   = fill_active;
    assign wr_fire   = s_valid & s_ready;
    assign last_beat = wr_fire && (wr_cnt == LAST);
    assign ce1       = wr_fire;
    assign we1       = wr_fire;
    assign d1        = s_data;

    assign m_valid  = (buf_cnt != 2'd0);
    assign m_data   = buf_data[buf_rd];
    assign m_last   = m_valid & buf_last[buf_rd];
    assign pop      = m_valid & m_ready;
    assign last_pop = pop & m_last;

    // Words buffered plus the read in flight, after this cycle's pop, must leave room.
    assign occ_next = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue    = drain_active && (rd_cnt < FLEN) && (occ_next < 3'd2);
    assign ce0      = issue;

`ifdef BRAM_STREAM_PINGPONG_EN
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wstate_t;
    typedef enum logic {R_WAIT, R_DRAIN} rstate_t;

    wstate_t    wstate;
    rstate_t    rstate;
    logic       wbank, rbank;
    logic [1:0] full, full_n;

    assign fill_active  = (wstate != W_IDLE) && !full[wbank];
    assign drain_active = (rstate == R_DRAIN);
    assign addr1        = {wbank, wr_cnt[AWIDTH-2:0]};
    assign addr0        = {rbank, rd_cnt[AWIDTH-2:0]};

    // A set and a clear can never target the same bank, so both apply.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full_n = full;
        if (last_beat) full_n[wbank] = 1'b1;
        if (last_pop)  full_n[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_IDLE;
            rstate <= R_WAIT;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            full   <= 2'b00;
        end else begin
            full <= full_n;
            case (wstate)
                W_IDLE: wstate <= W_FILL;
                W_FILL: if (last_beat) begin
                    wbank <= ~wbank;
                    if (full_n[~wbank]) wstate <= W_WAIT;
                end
                W_WAIT: if (!full[wbank]) wstate <= W_FILL;
                default: wstate <= W_IDLE;
            endcase
            case (rstate)
                R_WAIT:  if (full[rbank]) rstate <= R_DRAIN;
                R_DRAIN: if (last_pop) begin
                    rstate <= R_WAIT;
                    rbank  <= ~rbank;
                end
                default: rstate <= R_WAIT;
            endcase
        end
    end
`else
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t state;

    assign fill_active  = (state == FILL);
    assign drain_active = (state == DRAIN);
    assign addr1        = wr_cnt[AWIDTH-1:0];
    assign addr0        = rd_cnt[AWIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= FILL;
                FILL:    if (last_beat) state <= DRAIN;
                DRAIN:   if (last_pop)  state <= FILL;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // NOTE: the two buffer entries are reset because m_data must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            rd_idx_q    <= '0;
            rd_pend     <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= 2'b00;
            buf_rd      <= 1'b0;
            buf_wr      <= 1'b0;
            buf_cnt     <= 2'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_pop;
            if (wr_fire) wr_cnt <= last_beat ? '0 : wr_cnt + CW'(1);
            if (last_pop)   rd_cnt <= '0;
            else if (issue) rd_cnt <= rd_cnt + CW'(1);
            rd_pend  <= issue;
            rd_idx_q <= rd_cnt;
            // q0 belongs to the read issued last cycle; capture it with its end-of-frame tag.
            if (rd_pend) begin
                buf_data[buf_wr] <= q0;
                buf_last[buf_wr] <= (rd_idx_q == LAST);
                buf_wr           <= ~buf_wr;
            end
            if (pop) buf_rd <= ~buf_rd;
            buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_bram_stream_bridge.sv
// Bench for bram_stream_bridge: external RAM model, queue-based stream model,
// per-cycle compare process and directed frames (honours BRAM_STREAM_PINGPONG_EN).
module tb_bram_stream_bridge;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int FLEN = 8;
    localparam int HALF = 1 << (AW - 1);

    logic          clk, rst_n;
    logic [DW-1:0] s_data, m_data, d1, q0;
    logic          s_valid, s_ready, m_valid, m_ready, m_last, frame_done;
    logic [AW-1:0] addr1, addr0;
    logic          ce1, we1, ce0;

    bram_stream_bridge #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_done(frame_done), .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1),
        .addr0(addr0), .ce0(ce0), .q0(q0)
    );

    // External dual-port RAM with a registered read port.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ce1 && we1) mem[addr1] <= d1;
        if (ce0) q0 <= mem[addr0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic bp_mode = 1'b0;
    logic mr_level = 1'b0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : mr_level;
        end
    end

    // Stream model: every accepted input word is owed once, in order, on the output.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    int            addr_log[$];
    int cyc = 0, in_beats = 0, out_idx = 0, issued = 0, popped = 0;
    int fd_count = 0, blocked = 0, first_ce0 = -1, first_mv = -1;
    logic          fd_exp = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            in_beats = 0; out_idx = 0; issued = 0; popped = 0;
            fd_exp = 1'b0; prev_stall = 1'b0;
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_ce1", ce1, 0);
            check("rst_ce0", ce0, 0);
        end else begin
            check("frame_done", frame_done, fd_exp);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            check("ce1", ce1, s_valid & s_ready);
            check("we1", we1, s_valid & s_ready);
            if (s_valid && s_ready) begin
                int exp_addr;
                exp_addr = in_beats % FLEN;
`ifdef BRAM_STREAM_PINGPONG_EN
                exp_addr += ((in_beats / FLEN) % 2) * HALF;
`endif
                check("addr1", addr1, exp_addr);
                check("d1", d1, s_data);
                exp_q.push_back(s_data);
                addr_log.push_back(int'(addr1));
                in_beats++;
            end
            if (s_valid && !s_ready) blocked++;
            if (ce0) begin
                if (first_ce0 < 0) first_ce0 = cyc;
                issued++;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            fd_exp = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    check("m_data", m_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                check("m_last", m_last, out_idx == FLEN - 1);
                out_log.push_back(m_data);
                fd_exp  = (out_idx == FLEN - 1);
                out_idx = (out_idx + 1) % FLEN;
                popped++;
            end
            check("occupancy", (issued - popped) <= 2, 1);
            if (frame_done) fd_count++;
            prev_stall = m_valid & !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic send_word(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic send_frame(input int base, input logic hold);
        for (int i = 0; i < FLEN; i++) send_word(DW'(base + i));
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic clear_logs();
        out_log.delete();
        addr_log.delete();
        fd_count = 0; blocked = 0; first_ce0 = -1; first_mv = -1;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b1; s_data = 32'hdead;
        // Reset with input offered
        repeat (3) @(negedge clk);
        check("rst_m_last", m_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_we1", we1, 0);
        check("rst_addr0", addr0, 0);
        check("rst_addr1", addr1, 0);
        check("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        check("s_ready_idle", s_ready, 0);
        @(negedge clk);
        check("s_ready_rise", s_ready, 1);

        // Basic frame
        mr_level = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        send_frame(0, 1'b0);
        wait_idle();
        @(negedge clk);
        check("basic_count", out_log.size(), 8);
        check("basic_first", out_log[0], 0);
        check("basic_last", out_log[7], 7);
        check("basic_addr0", addr_log[0], 0);
        check("basic_addr7", addr_log[7], 7);
        check("basic_mvalid_lat", first_mv - first_ce0, 2);
        check("basic_fd_count", fd_count, 1);

        // Backpressure over 3 frames, input held valid between frames
        @(posedge clk); #1;
        clear_logs();
        bp_mode = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(32'h100 * (f + 1), f < 2);
        wait_idle();
        bp_mode = 1'b0;
        @(negedge clk); @(negedge clk);
        check("bp_count", out_log.size(), 24);
        check("bp_w9", out_log[9], 32'h201);
        check("bp_w23", out_log[23], 32'h307);
        check("bp_fd_count", fd_count, 3);
        check("bp_f3_addr", addr_log[16], 0);
`ifdef BRAM_STREAM_PINGPONG_EN
        check("bp_f2_addr", addr_log[8], HALF);
`else
        check("bp_f2_addr", addr_log[8], 0);
        check("bp_blocked", blocked >= FLEN, 1);
`endif

        // Reset right after output word 3
        @(posedge clk); #1;
        clear_logs();
        send_frame(32'ha0, 1'b0);
        for (int t = 0; t < 500 && out_log.size() < 4; t++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_outs", out_log.size(), 4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_log.delete();
        send_frame(32'h10, 1'b0);
        wait_idle();
        check("midrst_count", out_log.size(), 8);
        for (int i = 0; i < FLEN && i < out_log.size(); i++)
            check("midrst_word", out_log[i], 32'h10 + i);

`ifdef BRAM_STREAM_PINGPONG_EN
        // Back-to-back frames overlap fill and drain
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        send_frame(32'h40, 1'b1);
        send_frame(32'h50, 1'b0);
        wait_idle();
        check("pp_blocked", blocked, 0);
        check("pp_f2_addr_first", addr_log[8], HALF);
        check("pp_f2_addr_last", addr_log[15], HALF + 7);
        check("pp_f1_first", out_log[0], 32'h40);
        check("pp_f2_first", out_log[8], 32'h50);
        check("pp_f2_last", out_log[15], 32'h57);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
